// File: rtl/mul_unit.sv
// Sign-magnitude multiplier with a single registered output stage and valid strobe.
// Zero products always come out as all-zero; there is no negative zero.
module mul_unit #(
  parameter int MAG_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [MAG_W:0]     a,
  input  logic [MAG_W:0]     b,
  output logic [2*MAG_W:0]   product,
  output logic               out_valid
);

  function automatic logic [2*MAG_W-1:0] sm_mag(input logic [MAG_W:0] x,
                                                input logic [MAG_W:0] y);
    logic [2*MAG_W-1:0] xm;
    logic [2*MAG_W-1:0] ym;
    xm = {{MAG_W{1'b0}}, x[MAG_W-1:0]};
    ym = {{MAG_W{1'b0}}, y[MAG_W-1:0]};
    return xm * ym;
  endfunction

  function automatic logic sm_sign(input logic [MAG_W:0] x,
                                   input logic [MAG_W:0] y);
    return (x[MAG_W] ^ y[MAG_W]) & (|x[MAG_W-1:0]) & (|y[MAG_W-1:0]);
  endfunction

  // Stage p0: combinational magnitude product and zero-suppressed sign
  logic [2*MAG_W-1:0] mag_p0;
  logic               sign_p0;

  always_comb begin
    mag_p0  = sm_mag(a, b);
    sign_p0 = sm_sign(a, b);
  end

  // Stage p1: output register; product holds its value on idle cycles
  logic [2*MAG_W:0] product_p1;
  logic             vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        product_p1 <= {sign_p0, mag_p0};
      end
    end
  end

  assign product   = product_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: driver pushes expected products, a monitor pops and
// compares them whenever out_valid is seen.
module tb_mul_unit;
  localparam int MW = 2;
  localparam int OW = 2 * MW + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [MW:0]   a;
  logic [MW:0]   b;
  logic [OW-1:0] product;
  logic          out_valid;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  mul_unit #(.MAG_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .product(product), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as signed integers and multiply.
  function automatic logic [OW-1:0] model(input logic [MW:0] x, input logic [MW:0] y);
    int va;
    int vb;
    int p;
    int m;
    logic s;
    va = int'(x[MW-1:0]);
    vb = int'(y[MW-1:0]);
    if (x[MW]) va = -va;
    if (y[MW]) vb = -vb;
    p = va * vb;
    s = (p < 0);
    m = s ? -p : p;
    return {s, m[OW-2:0]};
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [MW:0] x, input logic [MW:0] y, input logic v);
    @(posedge clk);
    #1;
    in_valid = v;
    a = x;
    b = y;
    if (v) exp_q.push_back(model(x, y));
  endtask

  task automatic issue_exp(input logic [MW:0] x, input logic [MW:0] y,
                           input logic [OW-1:0] e);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {{(OW-1){1'b0}}, out_valid}, '0);
      end else begin
        chk("scoreboard_product", product, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] hold;
    logic [MW:0]   ra;
    logic [MW:0]   rb;

    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 3'b011;
    b = 3'b011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_product", product, '0);
    chk("reset_out_valid", {{(OW-1){1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(5'b01001);

    issue_exp(3'b101, 3'b011, 5'b10011);
    issue_exp(3'b111, 3'b110, 5'b00110);
    issue_exp(3'b100, 3'b111, 5'b00000);
    issue_exp(3'b110, 3'b000, 5'b00000);

    for (int i = 0; i < (1 << (MW + 1)); i++)
      for (int j = 0; j < (1 << (MW + 1)); j++)
        issue(i[MW:0], j[MW:0], 1'b1);

    // Valid gating: one pulse then three idle cycles with changing operands
    issue(3'b111, 3'b011, 1'b1);
    hold = model(3'b111, 3'b011);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 3'($urandom);
      b = 3'($urandom);
      #1;
      chk("idle_out_valid", {{(OW-1){1'b0}}, out_valid}, (k == 0) ? 5'd1 : 5'd0);
      chk("idle_product_hold", product, hold);
    end

    for (int n = 0; n < 200; n++) begin
      ra = 3'($urandom);
      rb = 3'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 3) != 0));
    end
    issue(3'b000, 3'b000, 1'b0);
    issue(3'b000, 3'b000, 1'b0);

    // Asynchronous reset while a result is on the outputs
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 3'b010;
    b = 3'b111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midstream_out_valid", {{(OW-1){1'b0}}, out_valid}, 5'd1);
    chk("midstream_product", product, model(3'b010, 3'b111));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_product", product, '0);
    chk("async_reset_out_valid", {{(OW-1){1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 20; n++) begin
      ra = 3'($urandom);
      rb = 3'($urandom);
      issue(ra, rb, 1'b1);
    end
    issue(3'b000, 3'b000, 1'b0);
    issue(3'b000, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", OW'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Sign-magnitude multiplier. Each operand is a sign bit plus an unsigned magnitude; the product is returned in the same format.
- The product magnitude is the unsigned product of the magnitudes. The product sign is the XOR of the operand signs, forced to 0 when either magnitude is zero, so there is no negative zero.
- Used as the multiply unit of the small signed calculator datapath.
- Output is registered, with a valid strobe.

Parameters:
- MAG_W, default 2: magnitude width of each operand. Operand width is MAG_W+1; product width is 2*MAG_W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; captured on the clk edge.
- a  input  MAG_W+1  operand A. a[MAG_W] is the sign (1 = negative); a[MAG_W-1:0] is the magnitude.
- b  input  MAG_W+1  operand B, same format as a.
- product  output  2*MAG_W+1  product[2*MAG_W] is the sign; product[2*MAG_W-1:0] is the magnitude.
- out_valid  output  1  product holds a new result this cycle.

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces product = 0 and out_valid = 0.
  - Outputs hold these values while rst_n is low.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- Magnitude:
  - mag = a[MAG_W-1:0] * b[MAG_W-1:0], unsigned, full 2*MAG_W width. No truncation or overflow is possible.
  - For MAG_W=2, the maximum is 3*3 = 9 = 4'b1001.
- Sign:
  - sign = (a[MAG_W] ^ b[MAG_W]) & (|a[MAG_W-1:0]) & (|b[MAG_W-1:0]).
  - Zero results are always all-zero, including -0 inputs (sign bit 1, magnitude 0).
- Latency and strobe:
  - Latency is 1 cycle. On a rising clk edge with in_valid=1, product <= {sign, mag} and out_valid <= 1.
  - On a rising clk edge with in_valid=0, out_valid <= 0 and product holds its last value.
- Back-to-back operation:
  - in_valid may be asserted every cycle. Throughput is 1 result per cycle, with no stall or backpressure.
- Reset mid-operation:
  - An in-flight result is discarded; outputs go to 0 as specified above.
- Combinational inputs:
  - a and b are sampled only at the clk edge.
  - Changes between edges do not affect outputs.
- Structure:
  - Purely synchronous datapath plus one output register stage.
  - No state machine; no latches.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=3'b011, b=3'b011 -> product=5'b00000, out_valid=0. Release rst_n; one edge later -> product=5'b01001, out_valid=1.
- Sign rules:
  - a=3'b101 (-1), b=3'b011 (+3) -> product=5'b10011.
  - a=3'b111 (-3), b=3'b110 (-2) -> product=5'b00110.
- Zero suppression:
  - a=3'b100 (-0), b=3'b111 -> product=5'b00000.
  - a=3'b110, b=3'b000 -> product=5'b00000.
- Exhaustive sweep: all 64 (a,b) pairs, one per cycle with in_valid=1 -> each product matches {sign rule, mag(a)*mag(b)} one cycle later, with out_valid=1 every cycle.
- Valid gating: in_valid pulse, then idle 3 cycles while a and b change -> out_valid high exactly one cycle; product is unchanged during idle.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> product and out_valid drop to 0 immediately, without waiting for a clk edge.
